booth_seq_ctrl: RTL and testbench

//  Iterative signed radix-4 Booth multiplier: a controller that sequences one shared partial-product stage over N/2 cycles.

---
 rtl/booth_pkg.sv | 34 +++
 rtl/booth_pp_sel.sv | 42 ++++
 rtl/booth_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_booth_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier.
// Holds the FSM state, Booth digit encoding and the digit decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    D_Z,
    D_P1,
    D_P2,
    D_M1,
    D_M2
  } digit_t;

  function automatic digit_t booth_decode(
    input logic [2:0] bits
  );
    digit_t d;
    d = D_Z;
    case (bits)
      3'b001, 3'b010: d = D_P1;
      3'b011:         d = D_P2;
      3'b100:         d = D_M2;
      3'b101, 3'b110: d = D_M1;
      default:        d = D_Z;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Booth partial-product operand select: 0, +-a or +-2a.
// Negation is one's complement here, the +1 leaves as adder carry-in.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  digit_t       digit,
  output logic [N+1:0] op,
  output logic         cin
);

  logic [N+1:0] a1;
  logic [N+1:0] a2;

  // N+2 bits so that -2a of the most negative a still fits
  assign a1 = {{2{a[N-1]}}, a};
  assign a2 = {a1[N:0], 1'b0};

  always_comb begin
    op  = '0;
    cin = 1'b0;
    case (digit)
      D_P1: op = a1;
      D_P2: op = a2;
      D_M1: begin
        op  = ~a1;
        cin = 1'b1;
      end
      D_M2: begin
        op  = ~a2;
        cin = 1'b1;
      end
      default: begin
        op  = '0;
        cin = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Iterative signed radix-4 Booth multiplier, one digit per cycle.
// Optional EARLY_TERM_EN: stop as soon as all remaining digits are zero.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic           busy
);

  localparam int CNT_W = $clog2(N/2+1);
  localparam int HALF  = N / 2;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(HALF - 1);

  state_t state_q, state_d;

  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [2*N:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zin_q, zin_d;
  logic [2*N-1:0]   p_q, p_d;

  digit_t         digit;
  logic [N+1:0]   op;
  logic           cin;
  logic [N+1:0]   hi;
  logic [N+1:0]   sum;
  logic [2*N+1:0] wide;
  logic [2*N:0]   shifted;
  logic           early;

  assign digit = booth_decode({b_q[1:0], zin_q});

  booth_pp_sel #(
    .N(N)
  ) u_pp_sel (
    .a    (a_q),
    .digit(digit),
    .op   (op),
    .cin  (cin)
  );

  assign hi   = {acc_q[2*N], acc_q[2*N:N]};
  assign sum  = hi + op + {{(N+1){1'b0}}, cin};
  assign wide = {sum, acc_q[N-1:0]};

`ifdef EARLY_TERM_EN
  int shamt;

  // b holds sign copies above its live bits, so this covers all of b
  assign early = (&b_q[N-1:1]) | ~(|b_q[N-1:1]);

  always_comb begin
    shamt = 2;
    if (early) begin
      shamt = 2 * (HALF - int'(cnt_q));
    end
  end

  assign shifted =
    (2*N+1)'($signed(wide) >>> shamt);
`else
  assign early = 1'b0;
  assign shifted =
    (2*N+1)'($signed(wide) >>> 2);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    zin_d   = zin_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          zin_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = shifted;
        b_d   = {{2{b_q[N-1]}}, b_q[N-1:2]};
        zin_d = b_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST || early) begin
          p_d     = shifted[2*N-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      zin_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      zin_q   <= zin_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = p_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: directed cases plus a random scoreboard.
// Products and latencies come from a plain arithmetic model.
module tb_booth_seq_ctrl;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   in_a = '0;
  logic [N-1:0]   in_b = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*N-1:0] out_p;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  booth_seq_ctrl #(
    .N(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .busy     (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [2*N-1:0] exp_p(
    input logic [N-1:0] a,
    input logic [N-1:0] b
  );
    logic signed [2*N-1:0] x;
    logic signed [2*N-1:0] y;
    x = {{N{a[N-1]}}, a};
    y = {{N{b[N-1]}}, b};
    return x * y;
  endfunction

  // cycles from accept to out_valid: with early termination, the first
  // k whose remaining multiplier bits are a pure sign run
  function automatic int exp_lat(input logic [N-1:0] b);
    int et;
    logic signed [N-1:0] sb;
    logic signed [N-1:0] r;
`ifdef EARLY_TERM_EN
    et = 1;
`else
    et = 0;
`endif
    sb = b;
    if (et == 1) begin
      for (int k = 1; k < N/2; k++) begin
        r = sb >>> (2*k - 1);
        if (r == 0 || r == -1) return k;
      end
    end
    return N/2;
  endfunction

  task automatic run_op(
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  int             stall,
    input  bit             noise,
    output logic [2*N-1:0] p,
    output int             lat
  );
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = N'($urandom);
    in_b     = N'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a     = N'($urandom);
        in_b     = N'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    p = out_p;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if (out_p !== '0)
      $display("FAIL reset_out_p: got %h want 0", out_p);
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL reset_busy: got %b want 0", busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [2*N-1:0] p;
    int lat;
    int low;
    p = '0;
    out_ready = 1'b1;
    in_a = 8'd3;
    in_b = 8'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    low = 0;
    lat = -1;
    while (!in_ready && low < 40) begin
      if (out_valid && lat < 0) begin
        lat = low;
        p   = out_p;
      end
      low++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    total++;
    if (p !== 16'd15)
      $display("FAIL basic_p: got %h want %h", p, 16'd15);
    else passed++;
    total++;
    if (lat != exp_lat(8'd5))
      $display("FAIL basic_lat: got %0d want %0d", lat, exp_lat(8'd5));
    else passed++;
    total++;
    if (low != exp_lat(8'd5) + 1)
      $display("FAIL basic_in_ready_low: got %0d want %0d",
               low, exp_lat(8'd5) + 1);
    else passed++;
  endtask

  task automatic test_corners();
    logic [N-1:0] ca[10] = '{8'h80, 8'h80, 8'h7f, 8'h00, 8'h5a,
                            8'h7f, 8'hff, 8'h01, 8'h80, 8'hc3};
    logic [N-1:0] cb[10] = '{8'h80, 8'h7f, 8'h80, 8'h9c, 8'h00,
                            8'h7f, 8'hff, 8'h80, 8'h01, 8'h2b};
    logic [2*N-1:0] p;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(ca[i], cb[i], 0, 1'b0, p, lat);
      total++;
      if (p !== exp_p(ca[i], cb[i]))
        $display("FAIL corner_p[%0d]: a=%h b=%h got %h want %h",
                 i, ca[i], cb[i], p, exp_p(ca[i], cb[i]));
      else passed++;
      total++;
      if (lat != exp_lat(cb[i]))
        $display("FAIL corner_lat[%0d]: got %0d want %0d",
                 i, lat, exp_lat(cb[i]));
      else passed++;
    end
    run_op(8'h80, 8'h80, 0, 1'b0, p, lat);
    total++;
    if (p !== 16'h4000)
      $display("FAIL min_times_min: got %h want 4000", p);
    else passed++;
    run_op(8'h80, 8'h7f, 0, 1'b0, p, lat);
    total++;
    if (p !== 16'hc080)
      $display("FAIL min_times_max: got %h want c080", p);
    else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    in_a = 8'hf9;
    in_b = 8'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != exp_lat(8'd9))
      $display("FAIL bp_lat: got %0d want %0d", lat, exp_lat(8'd9));
    else passed++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_p !== 16'hffc1) begin
        $display("FAIL bp_hold[%0d]: valid=%b p=%h want 1 ffc1",
                 i, out_valid, out_p);
        bad++;
      end else passed++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [2*N-1:0] p;
    int lat;
    in_a = 8'd100;
    in_b = 8'd100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_p !== '0 || busy !== 1'b0)
      $display("FAIL midrun_reset: rdy=%b vld=%b p=%h busy=%b want 1 0 0 0",
               in_ready, out_valid, out_p, busy);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrun_idle: vld=%b busy=%b want 0 0",
               out_valid, busy);
    else passed++;
    run_op(8'd2, 8'hfd, 0, 1'b0, p, lat);
    total++;
    if (p !== 16'hfffa)
      $display("FAIL after_reset_p: got %h want fffa", p);
    else passed++;
    total++;
    if (lat != exp_lat(8'hfd))
      $display("FAIL after_reset_lat: got %0d want %0d",
               lat, exp_lat(8'hfd));
    else passed++;
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2*N-1:0] p;
    int lat;
    for (int i = 0; i < 1500; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      run_op(a, b, $urandom_range(0, 2), 1'b1, p, lat);
      total++;
      if (p !== exp_p(a, b))
        $display("FAIL rand_p[%0d]: a=%h b=%h got %h want %h",
                 i, a, b, p, exp_p(a, b));
      else passed++;
      total++;
      if (lat != exp_lat(b))
        $display("FAIL rand_lat[%0d]: b=%h got %0d want %0d",
                 i, b, lat, exp_lat(b));
      else passed++;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL rand_idle[%0d]: rdy=%b vld=%b busy=%b want 1 0 0",
                 i, in_ready, out_valid, busy);
      else passed++;
    end
  endtask

`ifdef EARLY_TERM_EN
  task automatic test_early();
    logic [2*N-1:0] p;
    int lat;
    run_op(8'd7, 8'd1, 0, 1'b0, p, lat);
    total++;
    if (p !== 16'd7 || lat != 1)
      $display("FAIL early_b1: p=%h lat=%0d want 0007 1", p, lat);
    else passed++;
    run_op(8'd7, 8'hff, 0, 1'b0, p, lat);
    total++;
    if (p !== 16'hfff9 || lat != 1)
      $display("FAIL early_bm1: p=%h lat=%0d want fff9 1", p, lat);
    else passed++;
    run_op(8'd7, 8'h55, 0, 1'b0, p, lat);
    total++;
    if (p !== 16'd595 || lat != 4)
      $display("FAIL early_b55: p=%h lat=%0d want 0253 4", p, lat);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid_run();
`ifdef EARLY_TERM_EN
    test_early();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
